pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen.sv | 179 +++++++++++++++++
 tb/tb_pc_gen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Program-counter generator: selects the next fetch address, rejects misaligned
// control-flow targets and maintains a circular return-address stack.
module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            write,
  input  logic [2:0]      pc_sel,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc_base,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] trap_vec,
  input  logic [XLEN-1:0] epc,
  input  logic            ras_push,
  input  logic            ras_pop,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_prev,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_empty,
  output logic            misalign,
  output logic [XLEN-1:0] misalign_addr
);

  localparam int              PTR_W    = $clog2(RAS_DEPTH);
  localparam int              CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
  localparam logic [XLEN-1:0] STEP     = XLEN'(3'd4);
  localparam logic [XLEN-1:0] MASK_B0  = ~XLEN'(1'b1);
  localparam logic [XLEN-1:0] MASK_B10 = ~XLEN'(2'b11);

  logic [XLEN-1:0]  pc_r;
  logic [XLEN-1:0]  pc_prev_r;
  logic             misalign_r;
  logic [XLEN-1:0]  misalign_addr_r;
  logic [XLEN-1:0]  ras_mem_r [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr_r;
  logic [CNT_W-1:0] ras_cnt_r;

  logic [XLEN-1:0]  pc_plus4_s;
  logic [XLEN-1:0]  target_s;
  logic [XLEN-1:0]  ras_top_s;
  logic             ras_empty_s;
  logic             check_align_s;
  logic             hold_pc_s;
  logic             misalign_s;
  logic             accept_s;
  logic             do_push_s;
  logic             do_pop_s;
  logic             ras_we_s;
  logic [PTR_W-1:0] ras_widx_s;
  logic [PTR_W-1:0] ras_ptr_n_s;
  logic [CNT_W-1:0] ras_cnt_n_s;

  assign pc_plus4_s  = pc_r + STEP;
  assign ras_empty_s = (ras_cnt_r == '0);

  // Stack top view, derived from registered state only
  always_comb begin
    ras_top_s = '0;
    if (ras_empty_s) begin
      ras_top_s = '0;
    end else begin
      ras_top_s = ras_mem_r[ras_ptr_r];
    end
  end

  // Next-PC target mux and alignment-check qualification
  always_comb begin
    target_s      = pc_r;
    check_align_s = 1'b0;
    hold_pc_s     = 1'b0;
    case (pc_sel)
      3'b000: target_s = pc_plus4_s;
      3'b001: begin
        target_s      = pc_base + imm;
        check_align_s = 1'b1;
      end
      3'b010: begin
        target_s      = (rs_val + imm) & MASK_B0;
        check_align_s = 1'b1;
      end
      3'b011: target_s = trap_vec & MASK_B10;
      3'b100: target_s = epc & MASK_B10;
      3'b101: begin
        target_s      = ras_top_s;
        check_align_s = 1'b1;
      end
      default: begin
        target_s  = pc_r;
        hold_pc_s = 1'b1;
      end
    endcase
  end

  assign misalign_s = write & check_align_s & (target_s[1:0] != 2'b00);
  assign accept_s   = write & ~misalign_s;
  assign do_push_s  = accept_s & ras_push;
  assign do_pop_s   = accept_s & ras_pop;

  // Circular stack bookkeeping; push+pop on a non-empty stack rewrites the top in place
  always_comb begin
    ras_we_s    = 1'b0;
    ras_widx_s  = ras_ptr_r;
    ras_ptr_n_s = ras_ptr_r;
    ras_cnt_n_s = ras_cnt_r;
    if (do_push_s && do_pop_s && !ras_empty_s) begin
      ras_we_s   = 1'b1;
      ras_widx_s = ras_ptr_r;
    end else if (do_push_s) begin
      ras_we_s    = 1'b1;
      ras_ptr_n_s = ras_ptr_r + PTR_W'(1'b1);
      ras_widx_s  = ras_ptr_r + PTR_W'(1'b1);
      if (ras_cnt_r != CNT_FULL) begin
        ras_cnt_n_s = ras_cnt_r + CNT_W'(1'b1);
      end else begin
        ras_cnt_n_s = ras_cnt_r;
      end
    end else if (do_pop_s && !ras_empty_s) begin
      ras_ptr_n_s = ras_ptr_r - PTR_W'(1'b1);
      ras_cnt_n_s = ras_cnt_r - CNT_W'(1'b1);
    end else begin
      ras_we_s    = 1'b0;
      ras_ptr_n_s = ras_ptr_r;
      ras_cnt_n_s = ras_cnt_r;
    end
  end

  // PC and previous-PC registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r      <= RESET_VEC;
      pc_prev_r <= RESET_VEC;
    end else if (accept_s && !hold_pc_s) begin
      pc_r      <= target_s;
      pc_prev_r <= pc_r;
    end
  end

  // Misalignment pulse and sticky offending address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_r      <= 1'b0;
      misalign_addr_r <= '0;
    end else begin
      misalign_r <= misalign_s;
      if (misalign_s) begin
        misalign_addr_r <= target_s;
      end
    end
  end

  // Return-address stack storage, pointer and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_mem_r[i] <= '0;
      end
      ras_ptr_r <= '0;
      ras_cnt_r <= '0;
    end else begin
      if (ras_we_s) begin
        ras_mem_r[ras_widx_s] <= pc_plus4_s;
      end
      ras_ptr_r <= ras_ptr_n_s;
      ras_cnt_r <= ras_cnt_n_s;
    end
  end

  assign pc            = pc_r;
  assign pc_prev       = pc_prev_r;
  assign misalign      = misalign_r;
  assign misalign_addr = misalign_addr_r;
  assign ras_top       = ras_top_s;
  assign ras_empty     = ras_empty_s;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios with literal expectations, then random
// traffic compared every cycle against a queue-based reference model.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        write;
  logic [2:0]  pc_sel;
  logic [31:0] imm, pc_base, rs_val, trap_vec, epc;
  logic        ras_push, ras_pop;
  logic [31:0] pc, pc_prev, ras_top, misalign_addr;
  logic        ras_empty, misalign;

  pc_gen #(.XLEN(32), .RESET_VEC(32'h0000_0000), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .write(write), .pc_sel(pc_sel), .imm(imm),
    .pc_base(pc_base), .rs_val(rs_val), .trap_vec(trap_vec), .epc(epc),
    .ras_push(ras_push), .ras_pop(ras_pop), .pc(pc), .pc_prev(pc_prev),
    .ras_top(ras_top), .ras_empty(ras_empty), .misalign(misalign),
    .misalign_addr(misalign_addr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  // Reference state
  logic [31:0] m_pc, m_prev, m_maddr;
  logic        m_mis;
  logic [31:0] ras_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_top();
    if (ras_q.size() > 0) return ras_q[ras_q.size()-1];
    return 32'h0;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_prev = 32'h0; m_maddr = 32'h0; m_mis = 1'b0;
    ras_q.delete();
  endtask

  task automatic model_update();
    logic [31:0] tgt, ret;
    logic        chk;
    ret = m_pc + 32'd4;
    chk = 1'b0;
    case (pc_sel)
      3'd0: tgt = m_pc + 32'd4;
      3'd1: begin tgt = pc_base + imm; chk = 1'b1; end
      3'd2: begin tgt = (rs_val + imm) & 32'hFFFF_FFFE; chk = 1'b1; end
      3'd3: tgt = trap_vec & 32'hFFFF_FFFC;
      3'd4: tgt = epc & 32'hFFFF_FFFC;
      3'd5: begin tgt = model_top(); chk = 1'b1; end
      default: tgt = m_pc;
    endcase
    if (!write) begin
      m_mis = 1'b0;
    end else if (chk && tgt[1:0] != 2'b00) begin
      m_mis = 1'b1;
      m_maddr = tgt;
    end else begin
      m_mis = 1'b0;
      if (pc_sel <= 3'd5) begin
        m_prev = m_pc;
        m_pc = tgt;
      end
      if (ras_push && ras_pop && ras_q.size() > 0) begin
        ras_q[ras_q.size()-1] = ret;
      end else if (ras_push) begin
        ras_q.push_back(ret);
        if (ras_q.size() > 4) ras_q.delete(0);
      end else if (ras_pop && ras_q.size() > 0) begin
        ras_q.delete(ras_q.size()-1);
      end
    end
  endtask

  // Every-cycle comparison against the reference model
  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", pc, m_pc);
      check("pc_prev", pc_prev, m_prev);
      check("misalign", {31'd0, misalign}, {31'd0, m_mis});
      check("misalign_addr", misalign_addr, m_maddr);
      check("ras_top", ras_top, model_top());
      check("ras_empty", {31'd0, ras_empty}, {31'd0, (ras_q.size() == 0)});
    end
  end

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_update();
    #1;
  endtask

  task automatic drive(input logic w, input logic [2:0] s, input logic [31:0] b,
                       input logic [31:0] i, input logic [31:0] r,
                       input logic pu, input logic po);
    write = w; pc_sel = s; pc_base = b; imm = i; rs_val = r;
    ras_push = pu; ras_pop = po;
  endtask

  task automatic reset_pulse();
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_pulse_pc", pc, 32'h0);
    check("rst_pulse_prev", pc_prev, 32'h0);
    check("rst_pulse_empty", {31'd0, ras_empty}, 32'd1);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    trap_vec = 32'h0; epc = 32'h0;
    drive(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    model_reset();
    chk_en = 1'b1;
    #12;
    rst_n = 1'b1;
    check("reset_pc", pc, 32'h0);
    check("reset_prev", pc_prev, 32'h0);
    check("reset_ras_top", ras_top, 32'h0);
    check("reset_empty", {31'd0, ras_empty}, 32'd1);
    check("reset_misalign", {31'd0, misalign}, 32'd0);

    // Sequential fetch
    drive(1'b1, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle(); check("seq_pc1", pc, 32'h4); check("seq_prev1", pc_prev, 32'h0);
    cycle(); check("seq_pc2", pc, 32'h8); check("seq_prev2", pc_prev, 32'h4);
    cycle(); check("seq_pc3", pc, 32'hC); check("seq_prev3", pc_prev, 32'h8);

    // Stall then branch backwards
    drive(1'b1, 3'd1, 32'h100, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 3'd2, 32'h3, 32'h1, 32'h7, 1'b1, 1'b0);
    cycle(); check("stall_pc1", pc, 32'h100); check("stall_mis1", {31'd0, misalign}, 32'd0);
    drive(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle(); check("stall_pc2", pc, 32'h100); check("stall_empty", {31'd0, ras_empty}, 32'd1);
    drive(1'b1, 3'd1, 32'h100, 32'hFFFF_FFF8, 32'h0, 1'b0, 1'b0);
    cycle(); check("br_pc", pc, 32'hF8); check("br_prev", pc_prev, 32'h100);

    // Misaligned JALR rejected, aligned one accepted
    drive(1'b1, 3'd2, 32'h0, 32'h0, 32'h203, 1'b0, 1'b0);
    cycle();
    check("jalr_mis", {31'd0, misalign}, 32'd1);
    check("jalr_maddr", misalign_addr, 32'h202);
    check("jalr_pc_held", pc, 32'hF8);
    drive(1'b1, 3'd2, 32'h0, 32'h0, 32'h201, 1'b0, 1'b0);
    cycle();
    check("jalr_pc", pc, 32'h200);
    check("jalr_noflag", {31'd0, misalign}, 32'd0);
    check("jalr_maddr_held", misalign_addr, 32'h202);

    // Five pushes into a four-deep stack, then drain
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'd1, 32'(i * 16), 32'h0, 32'h0, 1'b0, 1'b0);
      cycle();
      drive(1'b1, 3'd1, 32'(i * 16), 32'h0, 32'h0, 1'b1, 1'b0);
      cycle();
    end
    check("ras_full_top", ras_top, 32'h44);
    drive(1'b1, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle(); check("pop1_top", ras_top, 32'h34);
    cycle(); check("pop2_top", ras_top, 32'h24);
    cycle(); check("pop3_top", ras_top, 32'h14);
    check("pop3_nonempty", {31'd0, ras_empty}, 32'd0);
    cycle(); check("pop4_empty", {31'd0, ras_empty}, 32'd1); check("pop4_top", ras_top, 32'h0);
    cycle(); check("pop5_empty", {31'd0, ras_empty}, 32'd1); check("pop5_mis", {31'd0, misalign}, 32'd0);

    // Return with simultaneous call
    drive(1'b1, 3'd1, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0); cycle();
    drive(1'b1, 3'd1, 32'h10, 32'h0, 32'h0, 1'b1, 1'b0); cycle();
    drive(1'b1, 3'd1, 32'h80, 32'h0, 32'h0, 1'b0, 1'b0); cycle();
    drive(1'b1, 3'd5, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1); cycle();
    check("ret_pc", pc, 32'h14);
    check("ret_top", ras_top, 32'h84);
    drive(1'b1, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1); cycle();
    check("ret_count1", {31'd0, ras_empty}, 32'd1);

    // Wrap-around and asynchronous reset pulse
    drive(1'b1, 3'd1, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0); cycle();
    drive(1'b1, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0); cycle();
    check("wrap_pc", pc, 32'h0);
    check("wrap_noflag", {31'd0, misalign}, 32'd0);
    drive(1'b1, 3'd1, 32'hFFFF_FFF0, 32'h20, 32'h0, 1'b1, 1'b0); cycle();
    check("wrap_add_pc", pc, 32'h10);
    reset_pulse();

    // Randomized traffic, including resets held across a clock edge
    for (int n = 0; n < 3000; n++) begin
      write    = ($urandom_range(0, 3) != 0);
      pc_sel   = 3'($urandom_range(0, 7));
      imm      = ($urandom_range(0, 3) == 0) ? $urandom() : (32'($urandom_range(0, 63)) - 32'd32);
      pc_base  = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC);
      rs_val   = $urandom();
      trap_vec = $urandom();
      epc      = $urandom();
      ras_push = ($urandom_range(0, 2) == 0);
      ras_pop  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        model_reset();
        cycle();
        rst_n = 1'b1;
      end else begin
        cycle();
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
